// File: rtl/seq_gen_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seq_gen_tx                                                   |
// | Description : Serial pattern transmitter. Takes a WIDTH-bit word over a    |
// |               valid/ready handshake, shifts it out MSB-first one bit per   |
// |               clock, flags nibble/frame boundaries and counts aligned      |
// |               nibbles equal to PATTERN.                                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module seq_gen_tx #(
    parameter int             WIDTH   = 16,
    parameter int             NIB     = 4,
    parameter logic [NIB-1:0] PATTERN = 4'b1011,
    parameter int             CW      = $clog2(WIDTH/NIB+1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             nib_last,
    output logic             frame_last,
    output logic             done,
    output logic [CW-1:0]    match_count
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int NW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [BW-1:0] c_last_bit = BW'(WIDTH - 1);
    localparam logic [NW-1:0] c_last_nib = NW'(NIB - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [BW-1:0]    bit_cnt_q;
    logic [NW-1:0]    nib_cnt_q;
    logic [NIB-2:0]   hist_q;      // previous NIB-1 bits sent, oldest in the MSB
    logic [CW-1:0]    match_q;

    logic             w_shift;
    logic             w_bit;
    logic             w_nib_last;
    logic [NIB-1:0]   w_nib;

    // Outputs are simple decodes of registered state; nothing from in_* reaches ser_*.
    assign w_shift     = (state_q == S_SHIFT);
    assign w_bit       = w_shift & shreg_q[WIDTH-1];
    assign w_nib_last  = w_shift && (nib_cnt_q == c_last_nib);
    assign w_nib       = {hist_q, w_bit};

    assign ser_valid   = w_shift;
    assign ser_out     = w_bit;
    assign nib_last    = w_nib_last;
    assign frame_last  = w_shift && (bit_cnt_q == c_last_bit);
    assign done        = (state_q == S_GAP);
    assign in_ready    = (state_q == S_IDLE) && rst_n;
    assign match_count = match_q;

    // Transmit FSM: capture in IDLE, shift WIDTH bits, one GAP cycle carrying done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            nib_cnt_q <= '0;
            hist_q    <= '0;
            match_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        shreg_q   <= in_data;
                        bit_cnt_q <= '0;
                        nib_cnt_q <= '0;
                        hist_q    <= '0;
                        match_q   <= '0;
                        state_q   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    shreg_q   <= {shreg_q[WIDTH-2:0], 1'b0};
                    bit_cnt_q <= bit_cnt_q + BW'(1);
                    nib_cnt_q <= (nib_cnt_q == c_last_nib) ? '0 : nib_cnt_q + NW'(1);
                    hist_q    <= w_nib[NIB-2:0];
                    // Aligned nibble completes this cycle; count it if it matches.
                    if (w_nib_last && (w_nib == PATTERN)) begin
                        match_q <= match_q + CW'(1);
                    end
                    if (bit_cnt_q == c_last_bit) begin
                        state_q <= S_GAP;
                    end
                end
                S_GAP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_gen_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_seq_gen_tx                                                |
// | Description : Directed self-checking bench for seq_gen_tx.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_seq_gen_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        ser_out;
    logic        ser_valid;
    logic        nib_last;
    logic        frame_last;
    logic        done;
    logic [2:0]  match_count;

    int errors = 0;
    int checks = 0;

    // Reference detector fed from the serial stream
    logic       det_clr = 1'b1;
    logic [3:0] det_sh;
    int         det_bits;
    int         det_cnt;

    seq_gen_tx dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .ser_out     (ser_out),
        .ser_valid   (ser_valid),
        .nib_last    (nib_last),
        .frame_last  (frame_last),
        .done        (done),
        .match_count (match_count)
    );

    always #5 clk = ~clk;

    // Detector counts aligned nibbles equal to 1011 using its own bit counter
    always @(posedge clk) begin
        if (det_clr) begin
            det_sh   <= '0;
            det_bits <= 0;
            det_cnt  <= 0;
        end else if (ser_valid) begin
            det_sh   <= {det_sh[2:0], ser_out};
            det_bits <= det_bits + 1;
            if ((det_bits % 4 == 3) && ({det_sh[2:0], ser_out} == 4'b1011))
                det_cnt <= det_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] wordf(input int c);
        logic [7:0] b;
        b = 8'(c);
        return {b, ~b};
    endfunction

    // Sends one frame from an idle cycle and checks every bit, flag and count.
    task automatic send_frame(input logic [15:0] w, input int exp_final, input string tag);
        int exp_mc;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL %s ready_before: got %b want 1", tag, in_ready);
        end
        in_data  = w;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_data  = ~w;
        exp_mc   = 0;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (ser_valid !== 1'b1) begin
                errors++; $display("FAIL %s ser_valid bit%0d: got %b want 1", tag, i, ser_valid);
            end
            checks++;
            if (ser_out !== w[15-i]) begin
                errors++; $display("FAIL %s ser_out bit%0d: got %b want %b", tag, i, ser_out, w[15-i]);
            end
            checks++;
            if (nib_last !== (i % 4 == 3)) begin
                errors++; $display("FAIL %s nib_last bit%0d: got %b want %b", tag, i, nib_last, (i % 4 == 3));
            end
            checks++;
            if (frame_last !== (i == 15)) begin
                errors++; $display("FAIL %s frame_last bit%0d: got %b want %b", tag, i, frame_last, (i == 15));
            end
            checks++;
            if (done !== 1'b0 || in_ready !== 1'b0) begin
                errors++; $display("FAIL %s done/ready bit%0d: got %b/%b want 0/0", tag, i, done, in_ready);
            end
            checks++;
            if (match_count !== 3'(exp_mc)) begin
                errors++; $display("FAIL %s match_count bit%0d: got %0d want %0d", tag, i, match_count, exp_mc);
            end
            if ((i % 4 == 3) && (w[(15-i)+:4] == 4'b1011)) exp_mc++;
            tick();
        end
        checks++;
        if (done !== 1'b1 || ser_valid !== 1'b0 || ser_out !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL %s gap: got done=%b sv=%b so=%b rdy=%b want 1 0 0 0",
                               tag, done, ser_valid, ser_out, in_ready);
        end
        checks++;
        if (match_count !== 3'(exp_final)) begin
            errors++; $display("FAIL %s final_count: got %0d want %0d", tag, match_count, exp_final);
        end
        tick();
        checks++;
        if (done !== 1'b0 || in_ready !== 1'b1 || match_count !== 3'(exp_final)) begin
            errors++; $display("FAIL %s idle_after: got done=%b rdy=%b cnt=%0d want 0 1 %0d",
                               tag, done, in_ready, match_count, exp_final);
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({ser_out, ser_valid, nib_last, frame_last, done} !== 5'b0 || match_count !== 3'd0) begin
            errors++; $display("FAIL reset_outputs: got so=%b sv=%b nl=%b fl=%b d=%b cnt=%0d want all 0",
                               ser_out, ser_valid, nib_last, frame_last, done, match_count);
        end
        #3 rst_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL reset_release: got rdy=%b done=%b want 1 0", in_ready, done);
        end
    endtask

    task automatic test_idle();
        for (int c = 0; c < 50; c++) begin
            checks++;
            if (ser_valid !== 1'b0 || in_ready !== 1'b1 || done !== 1'b0 || match_count !== 3'd0) begin
                errors++; $display("FAIL idle cyc%0d: got sv=%b rdy=%b d=%b cnt=%0d want 0 1 0 0",
                                   c, ser_valid, in_ready, done, match_count);
            end
            tick();
        end
    endtask

    task automatic test_frame_bbcb();
        send_frame(16'hBBCB, 3, "bbcb");
    endtask

    task automatic test_frame_patterns();
        send_frame(16'hBBBB, 4, "bbbb");
        send_frame(16'h0000, 0, "zero");
        send_frame(16'hB00B, 2, "b00b");
    endtask

    task automatic test_back_to_back();
        logic [15:0] rx;
        logic [15:0] exp_w [3];
        int nbits;
        int frames;
        exp_w[0] = 16'h00FF;
        exp_w[1] = 16'h12ED;
        exp_w[2] = 16'h24DB;
        rx = '0;
        nbits = 0;
        frames = 0;
        for (int c = 0; c < 54; c++) begin
            in_valid = 1'b1;
            in_data  = wordf(c);
            checks++;
            if (in_ready !== ((c == 0) || (c == 18) || (c == 36))) begin
                errors++; $display("FAIL b2b in_ready cyc%0d: got %b want %b",
                                   c, in_ready, ((c == 0) || (c == 18) || (c == 36)));
            end
            if (ser_valid === 1'b1) begin
                rx = {rx[14:0], ser_out};
                nbits++;
                if (nbits == 16) begin
                    checks++;
                    if (frames > 2 || rx !== exp_w[frames > 2 ? 2 : frames]) begin
                        errors++; $display("FAIL b2b word%0d: got %h want %h",
                                           frames, rx, exp_w[frames > 2 ? 2 : frames]);
                    end
                    frames++;
                    nbits = 0;
                end
            end
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (frames !== 3 || nbits !== 0) begin
            errors++; $display("FAIL b2b frame_count: got %0d (+%0d bits) want 3", frames, nbits);
        end
        tick();
    endtask

    task automatic test_reset_midframe();
        in_data  = 16'hBBBB;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (ser_valid !== 1'b1 || match_count !== 3'd1) begin
            errors++; $display("FAIL midrst_pre: got sv=%b cnt=%0d want 1 1", ser_valid, match_count);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({ser_out, ser_valid, nib_last, frame_last, done} !== 5'b0 || match_count !== 3'd0) begin
            errors++; $display("FAIL midrst_async: got so=%b sv=%b nl=%b fl=%b d=%b cnt=%0d want all 0",
                               ser_out, ser_valid, nib_last, frame_last, done, match_count);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (done !== 1'b0 || ser_valid !== 1'b0) begin
                errors++; $display("FAIL midrst_hold cyc%0d: got d=%b sv=%b want 0 0", i, done, ser_valid);
            end
        end
        #3 rst_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || done !== 1'b0 || ser_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_release: got rdy=%b d=%b sv=%b want 1 0 0", in_ready, done, ser_valid);
        end
        send_frame(16'hBBCB, 3, "after_rst");
    endtask

    task automatic test_loopback();
        det_clr = 1'b1;
        tick();
        det_clr = 1'b0;
        send_frame(16'hBBCB, 3, "loop");
        checks++;
        if (det_cnt !== 3 || 3'(det_cnt) !== match_count) begin
            errors++; $display("FAIL loopback: detector=%0d match_count=%0d want both 3", det_cnt, match_count);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_frame_bbcb();
        test_frame_patterns();
        test_back_to_back();
        test_reset_midframe();
        test_loopback();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
